// File: rtl/cnn_result_reader.sv
// Result memory readout engine: walks every kernel bank in address order and streams
// the words through a 2-entry elastic buffer on a valid/ready interface.
module cnn_result_reader #(
    parameter int N      = 4,
    parameter int LEN    = 16,
    parameter int DATA_W = 16,
    parameter int KW     = (N > 1) ? $clog2(N) : 1,
    parameter int AW     = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [KW-1:0]     rd_kernel,
    output logic [AW-1:0]     rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic [KW-1:0]     out_kernel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_end,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR   = AW'(LEN - 1);
    localparam logic [KW-1:0] LAST_KERNEL = KW'(N - 1);

    state_t                   r_state;
    logic [KW-1:0]            r_kernel;
    logic [AW-1:0]            r_addr;

    logic                     r_inflight;
    logic [KW-1:0]            r_tagKernel;
    logic                     r_tagLast;
    logic                     r_tagEnd;

    logic [1:0][DATA_W-1:0]   r_bufData;
    logic [1:0][KW-1:0]       r_bufKernel;
    logic [1:0]               r_bufLast;
    logic [1:0]               r_bufEnd;
    logic                     r_rdPtr;
    logic                     r_wrPtr;
    logic [1:0]               r_count;

    logic                     w_pop;
    logic                     w_push;
    logic [2:0]               w_level;
    logic                     w_atLastAddr;
    logic                     w_atLastKernel;

    assign w_pop          = out_valid & out_ready;
    assign w_push         = r_inflight;
    assign w_atLastAddr   = (r_addr == LAST_ADDR);
    assign w_atLastKernel = (r_kernel == LAST_KERNEL);

    // Words already buffered or in flight, minus the one leaving now, must leave room for one more.
    assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    assign rd_en     = (r_state == READ) && (w_level < 3'd2);
    assign rd_kernel = r_kernel;
    assign rd_addr   = r_addr;
    assign busy      = (r_state == READ) || (r_state == DRAIN);
    assign done      = (r_state == DONE);

    assign out_valid  = (r_count != 2'd0);
    assign out_data   = r_bufData[r_rdPtr];
    assign out_kernel = r_bufKernel[r_rdPtr];
    assign out_last   = r_bufLast[r_rdPtr];
    assign out_end    = r_bufEnd[r_rdPtr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_kernel <= '0;
            r_addr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= READ;
                        r_kernel <= '0;
                        r_addr   <= '0;
                    end
                end
                READ: begin
                    if (rd_en) begin
                        if (w_atLastAddr) begin
                            r_addr <= '0;
                            if (w_atLastKernel) begin
                                r_kernel <= '0;
                                r_state  <= DRAIN;
                            end else begin
                                r_kernel <= r_kernel + KW'(1);
                            end
                        end else begin
                            r_addr <= r_addr + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if ((r_count == 2'd0) && !r_inflight) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Tags travel with the read so they line up with rd_data one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight  <= 1'b0;
            r_tagKernel <= '0;
            r_tagLast   <= 1'b0;
            r_tagEnd    <= 1'b0;
        end else begin
            r_inflight <= rd_en;
            if (rd_en) begin
                r_tagKernel <= r_kernel;
                r_tagLast   <= w_atLastAddr;
                r_tagEnd    <= w_atLastAddr && w_atLastKernel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bufData   <= '0;
            r_bufKernel <= '0;
            r_bufLast   <= '0;
            r_bufEnd    <= '0;
            r_rdPtr     <= 1'b0;
            r_wrPtr     <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            if (w_push) begin
                r_bufData[r_wrPtr]   <= rd_data;
                r_bufKernel[r_wrPtr] <= r_tagKernel;
                r_bufLast[r_wrPtr]   <= r_tagLast;
                r_bufEnd[r_wrPtr]    <= r_tagEnd;
                r_wrPtr              <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_cnn_result_reader.sv
// Scoreboard bench for cnn_result_reader: a readout model fills an expected-word queue,
// a monitor pops it on every handshake; a second N=1/LEN=1 instance covers the degenerate size.
module tb_cnn_result_reader;

    localparam int N  = 2;
    localparam int LEN = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          rdEn;
    logic [0:0]    rdKernel;
    logic [1:0]    rdAddr;
    logic [DW-1:0] rdData;
    logic [DW-1:0] outData;
    logic [0:0]    outKernel;
    logic          outValid;
    logic          outReady;
    logic          outLast;
    logic          outEnd;
    logic          busy;
    logic          done;

    logic          startB;
    logic          rdEnB;
    logic [0:0]    rdKernelB;
    logic [0:0]    rdAddrB;
    logic [DW-1:0] rdDataB;
    logic [DW-1:0] outDataB;
    logic [0:0]    outKernelB;
    logic          outValidB;
    logic          outReadyB;
    logic          outLastB;
    logic          outEndB;
    logic          busyB;
    logic          doneB;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc0 = 0;
    int doneCount = 0;
    int wordIdx = 0;
    int outstanding = 0;
    int readyMode = 0;
    bit timingMode = 0;
    bit busyMode = 0;
    bit stallMode = 0;
    bit prevStall = 0;
    int prevPack = 0;
    int monRel = 0;
    int expQ[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    cnn_result_reader #(.N(N), .LEN(LEN), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_en(rdEn), .rd_kernel(rdKernel), .rd_addr(rdAddr), .rd_data(rdData),
        .out_data(outData), .out_kernel(outKernel), .out_valid(outValid), .out_ready(outReady),
        .out_last(outLast), .out_end(outEnd), .busy(busy), .done(done)
    );

    cnn_result_reader #(.N(1), .LEN(1), .DATA_W(DW)) dutB (
        .clk(clk), .rst(rst), .start(startB),
        .rd_en(rdEnB), .rd_kernel(rdKernelB), .rd_addr(rdAddrB), .rd_data(rdDataB),
        .out_data(outDataB), .out_kernel(outKernelB), .out_valid(outValidB), .out_ready(outReadyB),
        .out_last(outLastB), .out_end(outEndB), .busy(busyB), .done(doneB)
    );

    // Result memories: word = kernel*16 + addr, garbage when no read was issued the cycle before.
    always @(posedge clk) begin
        rdData  <= rdEn  ? 16'(int'(rdKernel) * 16 + int'(rdAddr))   : 16'hDEAD;
        rdDataB <= rdEnB ? 16'(int'(rdKernelB) * 16 + int'(rdAddrB)) : 16'hDEAD;
    end

    function automatic int packOut(input logic v, input logic [15:0] d, input logic k,
                                   input logic l, input logic e);
        return int'({v, d, k, l, e});
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference readout: kernel-major, ascending address, last/end flags from position.
    task automatic modelReadout();
        for (int k = 0; k < N; k++) begin
            for (int a = 0; a < LEN; a++) begin
                expQ.push_back(packOut(1'b1, 16'(k * 16 + a), 1'(k), a == LEN - 1,
                                       (k == N - 1) && (a == LEN - 1)));
            end
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        start = 1'b1;
        cyc0 = cyc;
        wordIdx = 0;
        modelReadout();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitCycle(input int rel);
        while (cyc - cyc0 < rel) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ignoredStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int target, input int budget);
        int n;
        n = 0;
        while (doneCount < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_reached", int'(doneCount >= target), 1);
    endtask

    task automatic finishReadout(input int target);
        repeat (5) @(negedge clk);
        checkOutput("done_count", doneCount, target);
        checkOutput("queue_empty", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_rd_en", int'(rdEn), 0);
        checkOutput("rst_rd_pos", int'({rdKernel, rdAddr}), 0);
        checkOutput("rst_out", packOut(outValid, outData, outKernel, outLast, outEnd), 0);
        checkOutput("rst_busy_done", int'({busy, done}), 0);
    endtask

    // out_ready patterns: always, stall window, toggling, random.
    initial begin
        outReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                1:       outReady = !((cyc - cyc0) >= 3 && (cyc - cyc0) <= 8);
                2:       outReady = (cyc % 2 == 0);
                3:       outReady = 1'($urandom_range(0, 1));
                default: outReady = 1'b1;
            endcase
        end
    end

    // Monitor: scoreboard pops, stall stability, occupancy bound, done and busy timing.
    always @(negedge clk) begin
        monRel = cyc - cyc0;
        if (!rst) begin
            outstanding = 0;
            prevStall = 0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_hold", packOut(outValid, outData, outKernel, outLast, outEnd), prevPack);
            end
            if (rdEn) begin
                checkOutput("outstanding_le_2",
                            int'(outstanding + 1 - int'(outValid && outReady) <= 2), 1);
            end
            outstanding = outstanding + int'(rdEn) - int'(outValid && outReady);
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_word", packOut(outValid, outData, outKernel, outLast, outEnd), 0);
                end else begin
                    checkOutput("word", packOut(outValid, outData, outKernel, outLast, outEnd),
                                expQ.pop_front());
                end
                if (timingMode) checkOutput("word_cycle", monRel, 3 + wordIdx);
                wordIdx++;
            end
            prevStall = outValid && !outReady;
            prevPack = packOut(outValid, outData, outKernel, outLast, outEnd);
            if (done) begin
                doneCount++;
                if (timingMode) checkOutput("done_cycle", monRel, 12);
            end
            if (busyMode && monRel >= 0 && monRel <= 14) begin
                checkOutput("busy_window", int'(busy), int'(monRel >= 1 && monRel <= 11));
            end
            if (stallMode && monRel == 8) begin
                checkOutput("stall_data", packOut(outValid, outData, 1'b0, 1'b0, 1'b0),
                            packOut(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0));
            end
        end
    end

    initial begin
        int wordsB;
        int donesB;
        int hsB;
        int dnB;
        rst = 1'b0;
        start = 1'b0;
        startB = 1'b0;
        outReadyB = 1'b1;
        #1;
        checkResetOutputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        $display("[TB] full-throughput readout");
        timingMode = 1;
        applyStimulus();
        waitDone(1, 40);
        timingMode = 0;
        finishReadout(1);

        $display("[TB] stalled consumer");
        readyMode = 1;
        stallMode = 1;
        applyStimulus();
        waitDone(2, 60);
        stallMode = 0;
        readyMode = 0;
        finishReadout(2);

        $display("[TB] toggling ready");
        readyMode = 2;
        applyStimulus();
        waitDone(3, 60);
        readyMode = 0;
        finishReadout(3);

        $display("[TB] start ignored while busy and in DONE");
        timingMode = 1;
        busyMode = 1;
        applyStimulus();
        waitCycle(5);
        ignoredStart();
        waitCycle(12);
        ignoredStart();
        waitDone(4, 40);
        finishReadout(4);
        timingMode = 0;
        busyMode = 0;

        $display("[TB] reset mid-readout");
        applyStimulus();
        waitCycle(6);
        #1;
        rst = 1'b0;
        #1;
        checkResetOutputs();
        expQ.delete();
        waitCycle(8);
        rst = 1'b1;
        applyStimulus();
        waitDone(5, 40);
        finishReadout(5);

        $display("[TB] random backpressure");
        readyMode = 3;
        for (int r = 0; r < 4; r++) begin
            applyStimulus();
            waitDone(6 + r, 120);
            finishReadout(6 + r);
        end
        readyMode = 0;

        $display("[TB] N=1 LEN=1 instance");
        wordsB = 0;
        donesB = 0;
        hsB = 0;
        dnB = 100;
        @(posedge clk);
        #1;
        startB = 1'b1;
        @(posedge clk);
        #1;
        startB = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (outValidB && outReadyB) begin
                wordsB++;
                hsB = i;
                checkOutput("n1_word", packOut(outValidB, outDataB, outKernelB, outLastB, outEndB),
                            packOut(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1));
            end
            if (doneB) begin
                donesB++;
                dnB = i;
            end
        end
        checkOutput("n1_words", wordsB, 1);
        checkOutput("n1_dones", donesB, 1);
        checkOutput("n1_done_delay", dnB - hsB, 2);
        checkOutput("n1_idle", int'(busyB), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
